// File: rtl/video_line_fetcher_if.sv
// SDRAM arbiter video-port bundle: burst read command, completion handshake and read data.
interface video_line_fetcher_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] addr_x16;
  logic        rdy;
  logic        ack;
  logic        resp_valid;
  logic [15:0] rdata;

  modport master (
    output cmd_valid, addr_x16, ack,
    input  cmd_ready, rdy, resp_valid, rdata
  );

  modport slave (
    input  cmd_valid, addr_x16, ack,
    output cmd_ready, rdy, resp_valid, rdata
  );
endinterface

// File: rtl/video_line_fetcher.sv
// Scanline fetcher: issues fixed-length SDRAM burst reads and buffers words in a FWFT pixel FIFO.
// Optional statistics outputs (underrun count, max request latency) under VIDEO_FETCH_STATS_EN.
module video_line_fetcher #(
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned LINE_WORDS  = 320,
  parameter int unsigned LINE_STRIDE = 320,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [23:0]                   base_addr_i,
  input  logic                          frame_start_i,
  input  logic                          line_start_i,
  video_line_fetcher_if.master          video_sdram,
  input  logic                          pix_rd_i,
  output logic [15:0]                   pix_data_o,
  output logic                          pix_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o
`ifdef VIDEO_FETCH_STATS_EN
  ,
  output logic [15:0]                   underrun_cnt_o,
  output logic [7:0]                    max_latency_o
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned BW = $clog2(BURST_LEN) + 1;
  localparam int unsigned WW = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, ACK} state_t;

  state_t         state;
  logic [WW-1:0]  words_left;
  logic [23:0]    next_addr;
  logic [23:0]    line_addr;
  logic [23:0]    line_src;
  logic [LW-1:0]  reserved;
  logic [LW-1:0]  level;
  logic [LW-1:0]  level_n;
  logic [LW:0]    free;
  logic [BW-1:0]  beat_cnt;
  logic           discard;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [15:0]    mem [FIFO_DEPTH];

  logic launch, hs, beat, push, pop, flush;

  always_comb begin
    free     = (LW+1)'(FIFO_DEPTH) - {1'b0, level} - {1'b0, reserved};
    line_src = frame_start_i ? base_addr_i : line_addr;
    // a launch is deferred by one cycle when a line/frame pulse arrives, so pointers see one writer
    launch   = (state == IDLE) && (words_left != '0) && (free >= (LW+1)'(BURST_LEN))
               && !frame_start_i && !line_start_i;
    hs       = (state == REQ) && video_sdram.cmd_valid && video_sdram.cmd_ready;
    beat     = (state == DATA) && video_sdram.resp_valid && (beat_cnt < BW'(BURST_LEN));
    push     = beat && !discard;
    flush    = ((state == ACK) && (discard || frame_start_i)) || ((state == IDLE) && frame_start_i);
    pop      = pix_rd_i && (level != '0) && !flush;
    level_n  = level;
    if (push && !pop) level_n = level + LW'(1);
    else if (pop && !push) level_n = level - LW'(1);
  end

  assign pix_data_o   = mem[rd_ptr];
  assign fifo_level_o = level;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= video_sdram.rdata;
  end

  // Burst bookkeeping (address, words_left, reservation) is committed when REQ is entered rather than
  // at the handshake; nothing observes it in between, and a line_start during REQ then cannot corrupt it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                 <= IDLE;
      video_sdram.cmd_valid <= 1'b0;
      video_sdram.addr_x16  <= '0;
      video_sdram.ack       <= 1'b0;
      words_left            <= '0;
      next_addr             <= '0;
      line_addr             <= '0;
      reserved              <= '0;
      beat_cnt              <= '0;
      discard               <= 1'b0;
      level                 <= '0;
      pix_empty_o           <= 1'b1;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      underrun_o            <= 1'b0;
    end else begin
      underrun_o <= pix_rd_i && (level == '0);

      if (frame_start_i) begin
        line_addr  <= base_addr_i;
        words_left <= '0;
        if (state != IDLE) discard <= 1'b1;
      end
      if (line_start_i) begin
        words_left <= WW'(LINE_WORDS);
        next_addr  <= line_src;
        line_addr  <= line_src + 24'(LINE_STRIDE);
      end

      unique case (state)
        IDLE: if (launch) begin
          state                 <= REQ;
          video_sdram.cmd_valid <= 1'b1;
          video_sdram.addr_x16  <= next_addr;
          next_addr             <= next_addr + 24'(BURST_LEN);
          words_left            <= words_left - WW'(BURST_LEN);
          reserved              <= reserved + LW'(BURST_LEN);
          beat_cnt              <= '0;
        end
        REQ: if (hs) begin
          video_sdram.cmd_valid <= 1'b0;
          state                 <= DATA;
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + BW'(1);
            reserved <= reserved - LW'(1);
          end
          if ((beat_cnt == BW'(BURST_LEN)) && video_sdram.rdy) begin
            state           <= ACK;
            video_sdram.ack <= 1'b1;
          end
        end
        ACK: begin
          video_sdram.ack <= 1'b0;
          state           <= IDLE;
          discard         <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (flush) begin
        level       <= '0;
        pix_empty_o <= 1'b1;
        rd_ptr      <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level       <= level_n;
        pix_empty_o <= (level_n == '0);
      end
    end
  end

`ifdef VIDEO_FETCH_STATS_EN
  logic [7:0] lat_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_cnt_o <= '0;
      max_latency_o  <= '0;
      lat_cnt        <= '0;
    end else begin
      if (launch) lat_cnt <= '0;
      else if ((state == REQ) && !hs && (lat_cnt != '1)) lat_cnt <= lat_cnt + 8'd1;
      if (frame_start_i) begin
        underrun_cnt_o <= '0;
        max_latency_o  <= '0;
      end else begin
        if (pix_rd_i && (level == '0) && (underrun_cnt_o != '1)) underrun_cnt_o <= underrun_cnt_o + 16'd1;
        if (hs && (lat_cnt > max_latency_o)) max_latency_o <= lat_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_line_fetcher.sv
// Directed bench for video_line_fetcher: a behavioural arbiter/SDRAM responder plus per-scenario tasks.
module tb_video_line_fetcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] base_addr;
  logic        frame_start, line_start, pix_rd;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic [6:0]  fifo_level;
  logic        underrun;
`ifdef VIDEO_FETCH_STATS_EN
  logic [15:0] underrun_cnt;
  logic [7:0]  max_latency;
`endif

  video_line_fetcher_if bus ();
  logic ready_en, early_rdy;
  assign bus.cmd_ready = ready_en;

  video_line_fetcher dut (
    .clk_i(clk), .rst_ni(rst_n), .base_addr_i(base_addr),
    .frame_start_i(frame_start), .line_start_i(line_start),
    .video_sdram(bus),
    .pix_rd_i(pix_rd), .pix_data_o(pix_data), .pix_empty_o(pix_empty),
    .fifo_level_o(fifo_level), .underrun_o(underrun)
`ifdef VIDEO_FETCH_STATS_EN
    , .underrun_cnt_o(underrun_cnt), .max_latency_o(max_latency)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [23:0] hs_addr[$];
  int beats_sent = 0;
  int ack_cnt = 0, ack_run = 0, ack_max_run = 0;
  bit ack_early = 1'b0;

  function automatic logic [15:0] word_of(input logic [23:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [23:0] hs_at(input int idx);
    if (idx < hs_addr.size()) return hs_addr[idx];
    return 'x;
  endfunction

  // Arbiter + SDRAM model: accepts a request, returns 8 beats of address-derived data, then rdy.
  initial begin
    logic [23:0] a;
    bus.resp_valid = 1'b0; bus.rdy = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_n && bus.cmd_valid && ready_en) begin
        a = bus.addr_x16;
        hs_addr.push_back(a);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk); #1;
          if (bus.ack) ack_early = 1'b1;
          bus.resp_valid = 1'b1; bus.rdata = word_of(a + 24'(i)); bus.rdy = early_rdy;
          beats_sent++;
        end
        @(negedge clk); #1;
        bus.resp_valid = 1'b0; bus.rdy = 1'b1;
        if (early_rdy) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        bus.rdy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.ack) begin ack_cnt++; ack_run++; end
    else begin
      if (ack_run > ack_max_run) ack_max_run = ack_run;
      ack_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic start_line(input logic [23:0] base, input bit same_cycle);
    @(negedge clk); base_addr = base; frame_start = 1'b1; line_start = same_cycle;
    @(negedge clk); frame_start = 1'b0; line_start = 1'b0;
    if (!same_cycle) begin
      line_start = 1'b1;
      @(negedge clk); line_start = 1'b0;
    end
  endtask

  task automatic cleanup();
    pix_rd = 1'b0; ready_en = 1'b1; early_rdy = 1'b0;
    @(negedge clk); base_addr = '0; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    checks++; if (bus.addr_x16 !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h want 000000", bus.addr_x16); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (pix_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", pix_empty); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_line_fetch();
    int h0, a0, k, cyc;
    h0 = hs_addr.size(); a0 = ack_cnt; k = 0; cyc = 0;
    start_line(24'h001000, 1'b0);
    while (k < 320 && cyc < 3000) begin
      @(negedge clk); cyc++;
      pix_rd = 1'b0;
      if (!pix_empty) begin
        checks++;
        if (pix_data !== word_of(24'h001000 + 24'(k))) begin
          errors++; $display("FAIL line_word[%0d]: got %h want %h", k, pix_data, word_of(24'h001000 + 24'(k)));
        end
        k++; pix_rd = 1'b1;
      end
    end
    @(negedge clk); pix_rd = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (k !== 320) begin errors++; $display("FAIL line_word_count: got %0d want 320", k); end
    checks++; if (hs_addr.size() - h0 !== 40) begin errors++; $display("FAIL line_bursts: got %0d want 40", hs_addr.size() - h0); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (hs_at(h0 + i) !== 24'h001000 + 24'(8 * i)) begin
        errors++; $display("FAIL line_addr[%0d]: got %h want %h", i, hs_at(h0 + i), 24'h001000 + 24'(8 * i));
      end
    end
    checks++; if (ack_cnt - a0 !== 40) begin errors++; $display("FAIL line_acks: got %0d want 40", ack_cnt - a0); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL line_level_end: got %0d want 0", fifo_level); end
    @(negedge clk); line_start = 1'b1;
    @(negedge clk); line_start = 1'b0;
    cyc = 0;
    while (hs_addr.size() <= h0 + 40 && cyc < 50) begin @(negedge clk); cyc++; end
    checks++; if (hs_at(h0 + 40) !== 24'h001140) begin errors++; $display("FAIL line2_addr: got %h want 001140", hs_at(h0 + 40)); end
    cleanup();
  endtask

  task automatic test_stall();
    int h0, cyc;
    h0 = hs_addr.size(); cyc = 0;
    ready_en = 1'b0;
    start_line(24'h002000, 1'b1);
    while (!bus.cmd_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL stall_req_seen: got %b want 1", bus.cmd_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.cmd_valid); end
      checks++; if (bus.addr_x16 !== 24'h002000) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 002000", i, bus.addr_x16); end
    end
    checks++; if (hs_addr.size() !== h0) begin errors++; $display("FAIL stall_no_hs: got %0d want %0d", hs_addr.size(), h0); end
    ready_en = 1'b1;
    cyc = 0;
    while (hs_addr.size() <= h0 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (hs_at(h0) !== 24'h002000) begin errors++; $display("FAIL stall_hs_addr: got %h want 002000", hs_at(h0)); end
    cleanup();
  endtask

  task automatic test_fifo_full();
    int h0;
    h0 = hs_addr.size();
    start_line(24'h003000, 1'b0);
    repeat (200) @(negedge clk);
    checks++; if (hs_addr.size() - h0 !== 8) begin errors++; $display("FAIL full_bursts: got %0d want 8", hs_addr.size() - h0); end
    checks++; if (fifo_level !== 7'd64) begin errors++; $display("FAIL full_level: got %0d want 64", fifo_level); end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL full_no_req: got %b want 0", bus.cmd_valid); end
    checks++; if (pix_data !== word_of(24'h003000)) begin errors++; $display("FAIL full_head: got %h want %h", pix_data, word_of(24'h003000)); end
    pix_rd = 1'b1;
    @(negedge clk); pix_rd = 1'b0;
    checks++; if (fifo_level !== 7'd63) begin errors++; $display("FAIL full_level_pop1: got %0d want 63", fifo_level); end
    checks++; if (pix_data !== word_of(24'h003001)) begin errors++; $display("FAIL full_head2: got %h want %h", pix_data, word_of(24'h003001)); end
    repeat (30) @(negedge clk);
    checks++; if (hs_addr.size() - h0 !== 8) begin errors++; $display("FAIL full_one_pop_no_req: got %0d want 8", hs_addr.size() - h0); end
    pix_rd = 1'b1;
    repeat (7) @(negedge clk);
    pix_rd = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (hs_addr.size() - h0 !== 9) begin errors++; $display("FAIL full_resume_bursts: got %0d want 9", hs_addr.size() - h0); end
    checks++; if (hs_at(h0 + 8) !== 24'h003040) begin errors++; $display("FAIL full_resume_addr: got %h want 003040", hs_at(h0 + 8)); end
    checks++; if (fifo_level !== 7'd64) begin errors++; $display("FAIL full_refill_level: got %0d want 64", fifo_level); end
    cleanup();
  endtask

  task automatic test_rdy_early();
    int h0, b0, cyc;
    h0 = hs_addr.size(); b0 = beats_sent; cyc = 0;
    early_rdy = 1'b1;
    start_line(24'h004000, 1'b0);
    while (hs_addr.size() <= h0 && cyc < 30) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (!bus.ack && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL early_ack_seen: got %b want 1", bus.ack); end
    checks++; if (beats_sent - b0 !== 8) begin errors++; $display("FAIL early_ack_after_beat8: beats %0d want 8", beats_sent - b0); end
    checks++; if (ack_early !== 1'b0) begin errors++; $display("FAIL early_ack_during_beats: got %b want 0", ack_early); end
    @(negedge clk);
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL early_ack_width: got %b want 0", bus.ack); end
    repeat (30) @(negedge clk);
    checks++; if (ack_max_run !== 1) begin errors++; $display("FAIL ack_max_width: got %0d want 1", ack_max_run); end
    cleanup();
  endtask

  task automatic test_frame_restart();
    int h0, b0, cyc;
    h0 = hs_addr.size(); b0 = beats_sent; cyc = 0;
    start_line(24'h005000, 1'b0);
    while (beats_sent - b0 < 3 && cyc < 40) begin @(negedge clk); cyc++; end
    base_addr = 24'h006000; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    cyc = 0;
    while (!bus.ack && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL restart_ack: got %b want 1", bus.ack); end
    checks++; if (beats_sent - b0 !== 8) begin errors++; $display("FAIL restart_beats: got %0d want 8", beats_sent - b0); end
    @(negedge clk);
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL restart_flush_level: got %0d want 0", fifo_level); end
    checks++; if (pix_empty !== 1'b1) begin errors++; $display("FAIL restart_flush_empty: got %b want 1", pix_empty); end
    repeat (5) @(negedge clk);
    checks++; if (hs_addr.size() - h0 !== 1) begin errors++; $display("FAIL restart_no_more_bursts: got %0d want 1", hs_addr.size() - h0); end
    line_start = 1'b1;
    @(negedge clk); line_start = 1'b0;
    cyc = 0;
    while (hs_addr.size() <= h0 + 1 && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (hs_at(h0 + 1) !== 24'h006000) begin errors++; $display("FAIL restart_new_base: got %h want 006000", hs_at(h0 + 1)); end
    cyc = 0;
    while (pix_empty && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if (pix_data !== word_of(24'h006000)) begin errors++; $display("FAIL restart_first_word: got %h want %h", pix_data, word_of(24'h006000)); end
    cleanup();
  endtask

  task automatic test_wrap_underrun();
    int h0, cyc;
    h0 = hs_addr.size(); cyc = 0;
    start_line(24'hFFFFF8, 1'b0);
    while (hs_addr.size() < h0 + 2 && cyc < 60) begin @(negedge clk); cyc++; end
    checks++; if (hs_at(h0) !== 24'hFFFFF8) begin errors++; $display("FAIL wrap_addr0: got %h want fffff8", hs_at(h0)); end
    checks++; if (hs_at(h0 + 1) !== 24'h000000) begin errors++; $display("FAIL wrap_addr1: got %h want 000000", hs_at(h0 + 1)); end
    cleanup();
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL wrap_flushed: got %0d want 0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_idle: got %b want 0", underrun); end
    pix_rd = 1'b1;
    @(negedge clk); pix_rd = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b want 1", underrun); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL underrun_level: got %0d want 0", fifo_level); end
    @(negedge clk);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b want 0", underrun); end
`ifdef VIDEO_FETCH_STATS_EN
    checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt); end
`endif
  endtask

  initial begin
    base_addr = '0; frame_start = 1'b0; line_start = 1'b0; pix_rd = 1'b0;
    ready_en = 1'b1; early_rdy = 1'b0;
    test_reset();
    test_line_fetch();
    test_stall();
    test_fifo_full();
    test_rdy_early();
    test_frame_restart();
    test_wrap_underrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
